// File: rtl/veldt_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : veldt_mem_arbiter
//  Description : Single-port RAM arbiter for Veldt fetch and load/store ports
//                with data priority, bounded fetch starvation, read-latency
//                owner tracking and fetch flush.
//  Revision    : 1.0  initial release
// ============================================================================
module veldt_mem_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 30
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int         LAST       = MEM_LATENCY - 1;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic       OWN_FETCH  = 1'b0;
    localparam logic       OWN_DATA   = 1'b1;

    logic [3:0]             starve_cnt_q;
    logic [3:0]             starve_cnt_d;
    logic [MEM_LATENCY-1:0] pipe_vld_q;
    logic [MEM_LATENCY-1:0] pipe_vld_d;
    logic [MEM_LATENCY-1:0] pipe_own_q;
    logic [MEM_LATENCY-1:0] pipe_own_d;
    logic                   force_if;

    // Byte-offset bits carry no meaning for a word-addressed RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // Data wins unless fetch has waited through STARVE_LIMIT data grants.
    always_comb begin
        force_if = if_req && (starve_cnt_q == STARVE_MAX);
        d_gnt    = !reset && d_req && !force_if;
        if_gnt   = !reset && if_req && !d_gnt;
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_be    = 4'hF;
            mem_addr  = if_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = 4'd0;
        end else if (d_gnt && (starve_cnt_q < STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // A flush kills fetch entries already in flight; the fetch granted in the
    // flush cycle itself enters stage 0 untouched.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_own_d    = '0;
        pipe_vld_d[0] = if_gnt | (d_gnt & ~d_we);
        pipe_own_d[0] = d_gnt ? OWN_DATA : OWN_FETCH;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1] &
                            ~(if_flush & (pipe_own_q[i-1] == OWN_FETCH));
            pipe_own_d[i] = pipe_own_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            pipe_vld_q   <= '0;
            pipe_own_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_own_q   <= pipe_own_d;
        end
    end

    always_comb begin
        if_rvalid = !reset && pipe_vld_q[LAST] &&
                    (pipe_own_q[LAST] == OWN_FETCH) && !if_flush;
        d_rvalid  = !reset && pipe_vld_q[LAST] &&
                    (pipe_own_q[LAST] == OWN_DATA);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_veldt_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_veldt_mem_arbiter
//  Description : Scoreboard bench driving MEM_LATENCY=1 and =2 arbiters with
//                identical traffic against a reference memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_veldt_mem_arbiter;

    localparam int SLIM = 4;

    logic clock = 1'b0;
    logic reset;
    logic if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    logic [1:0]        if_gnt_w, if_rvalid_w, d_gnt_w, d_rvalid_w, mem_en_w, mem_we_w;
    logic [1:0][31:0]  if_rdata_w, d_rdata_w, mem_wdata_w, mem_rdata_w;
    logic [1:0][3:0]   mem_be_w;
    logic [1:0][29:0]  mem_addr_w;

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00010101;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] ram [64];
        logic [31:0] rd1, rd2;

        initial for (int i = 0; i < 64; i++) ram[i] = init_word(i);

        always @(posedge clock) begin
            if (mem_en_w[k]) begin
                if (mem_we_w[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_w[k][b])
                            ram[mem_addr_w[k][5:0]][8*b +: 8] <= mem_wdata_w[k][8*b +: 8];
                end else begin
                    rd1 <= ram[mem_addr_w[k][5:0]];
                end
            end
            rd2 <= rd1;
        end
        assign mem_rdata_w[k] = (k == 0) ? rd1 : rd2;

        veldt_mem_arbiter #(
            .MEM_LATENCY (k + 1),
            .STARVE_LIMIT(SLIM),
            .ADDR_W      (30)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_flush (if_flush),
            .if_gnt   (if_gnt_w[k]),
            .if_rvalid(if_rvalid_w[k]),
            .if_rdata (if_rdata_w[k]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_be     (d_be),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt_w[k]),
            .d_rvalid (d_rvalid_w[k]),
            .d_rdata  (d_rdata_w[k]),
            .mem_en   (mem_en_w[k]),
            .mem_we   (mem_we_w[k]),
            .mem_be   (mem_be_w[k]),
            .mem_addr (mem_addr_w[k]),
            .mem_wdata(mem_wdata_w[k]),
            .mem_rdata(mem_rdata_w[k])
        );
    end

    typedef struct packed {
        int          due;
        logic        own;
        logic [31:0] data;
    } resp_t;

    resp_t       sb [2][$];
    logic [31:0] ref_mem [64];
    int          cyc;
    int          scnt;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  seen_ig, seen_dg;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic step(input logic rst, input logic ireq, input logic [31:0] iaddr,
                        input logic iflush, input logic dreq, input logic dwe,
                        input logic [3:0] dbe, input logic [31:0] daddr,
                        input logic [31:0] dwdata);
        logic        e_force, e_dg, e_ig, e_en, e_we;
        logic [3:0]  e_be;
        logic [29:0] e_addr;
        logic [31:0] e_wd, x_ir, x_dr;
        logic        x_iv, x_dv;
        resp_t       r;
        string       p;
        reset = rst; if_req = ireq; if_addr = iaddr; if_flush = iflush;
        d_req = dreq; d_we = dwe; d_be = dbe; d_addr = daddr; d_wdata = dwdata;
        @(negedge clock);
        e_force = ireq && (scnt == SLIM);
        e_dg    = !rst && dreq && !e_force;
        e_ig    = !rst && ireq && !e_dg;
        e_en    = e_dg || e_ig;
        e_we    = e_dg && dwe;
        e_addr  = e_dg ? daddr[31:2] : (e_ig ? iaddr[31:2] : 30'd0);
        e_be    = e_dg ? dbe : (e_ig ? 4'hF : 4'h0);
        e_wd    = e_dg ? dwdata : 32'h0;
        seen_ig = if_gnt_w;
        seen_dg = d_gnt_w;
        for (int k = 0; k < 2; k++) begin
            p = $sformatf("L%0d", k + 1);
            check({p, " if_gnt"},    64'(if_gnt_w[k]), 64'(e_ig));
            check({p, " d_gnt"},     64'(d_gnt_w[k]),  64'(e_dg));
            check({p, " mem_ctl"},   64'({mem_en_w[k], mem_we_w[k], mem_be_w[k]}),
                                     64'({e_en, e_we, e_be}));
            check({p, " mem_addr"},  64'(mem_addr_w[k]),  64'(e_addr));
            check({p, " mem_wdata"}, 64'(mem_wdata_w[k]), 64'(e_wd));
            x_iv = 1'b0; x_dv = 1'b0; x_ir = 32'h0; x_dr = 32'h0;
            if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                r = sb[k].pop_front();
                if (!rst) begin
                    if (r.own) begin
                        x_dv = 1'b1; x_dr = r.data;
                    end else if (!iflush) begin
                        x_iv = 1'b1; x_ir = r.data;
                    end
                end
            end
            check({p, " if_rvalid"}, 64'(if_rvalid_w[k]), 64'(x_iv));
            check({p, " if_rdata"},  64'(if_rdata_w[k]),  64'(x_ir));
            check({p, " d_rvalid"},  64'(d_rvalid_w[k]),  64'(x_dv));
            check({p, " d_rdata"},   64'(d_rdata_w[k]),   64'(x_dr));
            if (rst) begin
                sb[k].delete();
            end else begin
                if (iflush)
                    for (int j = sb[k].size() - 1; j >= 0; j--)
                        if (!sb[k][j].own) sb[k].delete(j);
                if (e_ig || (e_dg && !dwe))
                    sb[k].push_back('{due: cyc + k + 1, own: e_dg, data: ref_mem[e_addr[5:0]]});
            end
        end
        if (e_we)
            for (int b = 0; b < 4; b++)
                if (dbe[b]) ref_mem[e_addr[5:0]][8*b +: 8] = dwdata[8*b +: 8];
        if (rst || e_ig || !ireq) scnt = 0;
        else if (e_dg && scnt < SLIM) scnt++;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        reset = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        scnt = 0; cyc = 0;
        @(posedge clock);
        #1;

        // Reset with both requests asserted: nothing granted.
        step(1, 1, 32'h4, 0, 1, 0, 4'h0, 32'h8, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch-only stream.
        step(0, 1, 32'h0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h8, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Partial write, then read it back.
        step(0, 0, 0, 0, 1, 1, 4'b0011, 32'h10, 32'hDEADBEEF);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 4'h0, 32'h12, 0);
        idle(2);

        // Contention: D,D,D,D,F repeating.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h40 + 32'(4 * i), 0, 1, 0, 0, 32'h80 + 32'(4 * i), 0);
            check("contention if_gnt", 64'(seen_ig[0]), 64'((i % 5) == 4));
            check("contention exclusive", 64'(seen_ig[1] & seen_dg[1]), 64'd0);
        end
        idle(2);

        // Flush with a post-redirect fetch in the same cycle.
        step(0, 1, 32'h20, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h24, 1, 0, 0, 0, 0, 0);
        idle(3);

        // Mixed ownership: data read then fetch.
        step(0, 0, 0, 0, 1, 0, 0, 32'h30, 0);
        step(0, 1, 32'h34, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Flush leaves data responses alone.
        step(0, 0, 0, 0, 1, 0, 0, 32'h38, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Reset mid-flight.
        step(0, 0, 0, 0, 1, 0, 0, 32'h3C, 0);
        step(1, 1, 32'h4, 0, 1, 0, 0, 32'h8, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom(), $urandom());
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
